qos_port_sched: RTL and testbench



---
 rtl/qos_port_sched.sv | 116 +++++++++++
 tb/tb_qos_port_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/qos_port_sched.sv
// Output-port arbiter with wormhole locking. The winner class is aged requesters
// first, then QoS requesters, then any requester, with a round-robin pick inside the class.
module qos_port_sched #(
  parameter int WIDTH   = 4,
  parameter int AGE_MAX = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req,
  input  logic [WIDTH-1:0]         qos,
  input  logic [WIDTH-1:0]         tail,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         gnt,
  output logic                     xfer,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] sel_idx
);

  localparam int IW = $clog2(WIDTH);
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [AW-1:0] AGE_TOP = AW'(AGE_MAX);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    sel_q, sel_d, rr_q, rr_d;
  logic [AW-1:0]    age_q [WIDTH];
  logic [AW-1:0]    age_d [WIDTH];
  logic [WIDTH-1:0] aged, hi, cls;
  logic [IW-1:0]    win_idx;
  logic             win_vld;
  logic             own_xfer, tail_xfer;

  // Returns {found, index} of the first set bit at or above ptr, wrapping.
  // Scanning from the far end downward lets the nearest hit overwrite the others.
  function automatic logic [IW:0] rr_pick(input logic [WIDTH-1:0] vec,
                                          input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (vec[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < WIDTH; i++) aged[i] = req[i] && (age_q[i] == AGE_TOP);
    hi  = req & qos;
    cls = (|aged) ? aged : ((|hi) ? hi : req);
    {win_vld, win_idx} = rr_pick(cls, rr_q);
  end

  assign own_xfer  = (|(gnt_q & req)) & out_ready;
  assign tail_xfer = own_xfer & tail[sel_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = LOCKED;
          gnt_d   = WIDTH'(1) << win_idx;
          sel_d   = win_idx;
        end
      end
      LOCKED: begin
        // Only the tail flit releases the port; nothing else can preempt the owner.
        if (tail_xfer) begin
          state_d = IDLE;
          gnt_d   = '0;
          sel_d   = '0;
          rr_d    = (sel_q == IW'(WIDTH - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      age_d[i] = age_q[i];
      if (!req[i]) age_d[i] = '0;
      else if (state_q == IDLE && win_vld && win_idx == IW'(i)) age_d[i] = '0;
      else if (!gnt_q[i] && age_q[i] != AGE_TOP) age_d[i] = age_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
      for (int i = 0; i < WIDTH; i++) age_q[i] <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      for (int i = 0; i < WIDTH; i++) age_q[i] <= age_d[i];
    end
  end

  assign gnt     = gnt_q;
  assign sel_idx = sel_q;
  assign busy    = (state_q == LOCKED);
  assign xfer    = own_xfer;

endmodule

// File: tb/tb_qos_port_sched.sv
// Directed and random bench for qos_port_sched (WIDTH=4, AGE_MAX=3) against an
// integer-level model of owner, round-robin pointer and per-requester wait ages.
module tb_qos_port_sched;

  localparam int W  = 4;
  localparam int AM = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [W-1:0]         req, qos, tail;
  logic                 out_ready;
  logic [W-1:0]         gnt;
  logic                 xfer, busy;
  logic [$clog2(W)-1:0] sel_idx;

  int total = 0;
  int bad   = 0;

  int m_owner;
  int m_rr;
  int m_age [W];

  always #5 clk = ~clk;

  qos_port_sched #(.WIDTH(W), .AGE_MAX(AM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .qos(qos), .tail(tail),
    .out_ready(out_ready), .gnt(gnt), .xfer(xfer), .busy(busy), .sel_idx(sel_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_rr    = 0;
    for (int i = 0; i < W; i++) m_age[i] = 0;
  endtask

  function automatic logic [W-1:0] m_gnt();
    logic [W-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic m_xfer();
    return (m_owner >= 0) && req[m_owner] && out_ready;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic m_clock();
    logic [W-1:0] aged, cls;
    int win, j;
    int nage [W];
    win = -1;
    if (m_owner < 0 && req != '0) begin
      aged = '0;
      for (int i = 0; i < W; i++) aged[i] = req[i] && (m_age[i] == AM);
      if (aged != '0)         cls = aged;
      else if ((req & qos) != '0) cls = req & qos;
      else                    cls = req;
      for (int k = 0; k < W; k++) begin
        j = (m_rr + k) % W;
        if (win < 0 && cls[j]) win = j;
      end
    end
    for (int i = 0; i < W; i++) begin
      if (!req[i])                       nage[i] = 0;
      else if (i == win)                 nage[i] = 0;
      else if (i == m_owner)             nage[i] = m_age[i];
      else                               nage[i] = (m_age[i] + 1 > AM) ? AM : m_age[i] + 1;
    end
    for (int i = 0; i < W; i++) m_age[i] = nage[i];
    if (m_owner < 0) begin
      if (win >= 0) m_owner = win;
    end else if (req[m_owner] && out_ready && tail[m_owner]) begin
      m_rr    = (m_owner + 1) % W;
      m_owner = -1;
    end
  endtask

  task automatic cyc(input logic [W-1:0] r, input logic [W-1:0] q,
                     input logic [W-1:0] t, input logic rdy);
    req = r; qos = q; tail = t; out_ready = rdy;
    #1;
    chk("xfer", 32'(xfer), 32'(m_xfer()));
    m_clock();
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), 32'(m_gnt()));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("sel_idx", 32'(sel_idx), 32'((m_owner >= 0) ? m_owner : 0));
    chk("onehot0", 32'($countones(gnt) <= 1), 32'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sel", 32'(sel_idx), 32'(0));
    chk("rst_xfer", 32'(xfer), 32'(0));
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; qos = '0; tail = '0; out_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Alternating single-flit packets with one IDLE cycle between grants.
    cyc(4'b1010, 4'b0000, 4'b1111, 1'b1); chk("r32_c1", 32'(gnt), 32'(4'b0010));
    cyc(4'b1010, 4'b0000, 4'b1111, 1'b1); chk("r32_c2", 32'(gnt), 32'(4'b0000));
    cyc(4'b1010, 4'b0000, 4'b1111, 1'b1); chk("r32_c3", 32'(gnt), 32'(4'b1000));
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b1); chk("lock_hold", 32'(gnt), 32'(4'b1000));
    do_reset();

    // QoS outranks the round-robin pointer.
    cyc(4'b0111, 4'b0100, 4'b0000, 1'b1); chk("r33_qos", 32'(gnt), 32'(4'b0100));
    do_reset();

    // Three-flit packet with a stall; a QoS requester cannot preempt.
    cyc(4'b0010, 4'b0000, 4'b0000, 1'b1); chk("r34_g", 32'(gnt), 32'(4'b0010));
    cyc(4'b1010, 4'b1000, 4'b0000, 1'b1); chk("r34_f1", 32'(gnt), 32'(4'b0010));
    cyc(4'b1010, 4'b1000, 4'b0000, 1'b0); chk("r34_st", 32'(gnt), 32'(4'b0010));
    cyc(4'b1010, 4'b1000, 4'b0000, 1'b1); chk("r34_f2", 32'(gnt), 32'(4'b0010));
    cyc(4'b1010, 4'b1000, 4'b0010, 1'b1); chk("r34_tl", 32'(gnt), 32'(4'b0000));
    cyc(4'b1010, 4'b1000, 4'b0000, 1'b1); chk("r34_nx", 32'(gnt), 32'(4'b1000));

    // Reset while busy, then a fresh grant from rr_ptr=0.
    do_reset();
    cyc(4'b1000, 4'b0000, 4'b0000, 1'b1); chk("r36_g", 32'(gnt), 32'(4'b1000));
    do_reset();

    // Aged low-priority requester beats pending QoS requesters.
    cyc(4'b1101, 4'b1100, 4'b1111, 1'b1); chk("r35_1", 32'(gnt), 32'(4'b0100));
    cyc(4'b1101, 4'b1100, 4'b1111, 1'b1); chk("r35_2", 32'(gnt), 32'(4'b0000));
    cyc(4'b1101, 4'b1100, 4'b1111, 1'b1); chk("r35_3", 32'(gnt), 32'(4'b1000));
    cyc(4'b1101, 4'b1100, 4'b1111, 1'b1); chk("r35_4", 32'(gnt), 32'(4'b0000));
    cyc(4'b1101, 4'b1100, 4'b1111, 1'b1); chk("r35_5", 32'(gnt), 32'(4'b0001));

    // Random traffic, with an occasional asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] r, q, t;
      r = W'($urandom);
      q = W'($urandom);
      t = W'($urandom) & W'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc(r, q, t, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
